// File: rtl/keypad_digit_buffer.sv
// keypad_digit_buffer
//   Sits behind the 10-key encoder. Debounces press and release, accepts one
//   BCD digit per physical press and shifts accepted digits into an entry
//   buffer. A commit hands the entered value to the consumer.
//
//   Optional build macro: KEYBUF_ROLLOVER_EN
//     defined   : accepting while full shifts anyway and drops the oldest digit
//                 (overflow is never asserted)
//     undefined : accepting while full drops the new digit and pulses overflow
//
// Parameters
//   DIGITS   : BCD digits held in the buffer (1..8)
//   DEBOUNCE : consecutive identical samples needed for press/release (1..255)
//
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   code_in     : encoder code, [4]=pressed, [3:0]=BCD digit
//   clr         : clear the entry buffer
//   commit      : copy buffer to value_out and clear the buffer
//   digits_out  : entry buffer, newest digit in [3:0]
//   count       : number of digits entered
//   full        : count == DIGITS
//   key_strobe  : one-cycle pulse per accepted digit
//   overflow    : one-cycle pulse when a digit is dropped (buffer full)
//   key_error   : one-cycle pulse when a press carries a digit > 9
//   value_out   : last committed value
//   value_valid : one-cycle pulse when value_out updates
module keypad_digit_buffer #(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [4:0]                      code_in,
  input  logic                            clr,
  input  logic                            commit,
  output logic [4*DIGITS-1:0]             digits_out,
  output logic [$clog2(DIGITS+1)-1:0]     count,
  output logic                            full,
  output logic                            key_strobe,
  output logic                            overflow,
  output logic                            key_error,
  output logic [4*DIGITS-1:0]             value_out,
  output logic                            value_valid
);

  localparam int               CW       = $clog2(DIGITS + 1);
  localparam int               DW       = 4 * DIGITS;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DIGITS);
  localparam logic [8:0]       DB_LIM   = 9'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [3:0]      r_cand;
  logic            w_cand_load;
  logic            w_accept;
  logic            w_err;
  logic            w_cnt_hit;
  logic [3:0]      w_acc_digit;

  logic [DW-1:0]   r_digits;
  logic [CW-1:0]   r_count;
  logic            r_strobe;
  logic            r_ovf;
  logic            r_err;
  logic [DW-1:0]   r_value;
  logic            r_valid;

  logic            w_commit_go;
  logic [DW-1:0]   w_base_digits;
  logic [CW-1:0]   w_base_count;
  logic [DW-1:0]   w_shifted;

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cand_load) begin
        r_cand <= code_in[3:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next state, accept and error decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_load = 1'b0;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    // True on the sample that makes the run of identical samples DEBOUNCE long
    w_cnt_hit   = (({1'b0, r_cnt} + 9'd1) == DB_LIM);

    unique case (r_state)
      IDLE: begin
        if (code_in[4]) begin
          if (code_in[3:0] <= 4'd9) begin
            w_cand_load = 1'b1;
            if (DEBOUNCE == 1) begin
              w_accept    = 1'b1;
              w_state_nxt = HELD;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = PRESS_DB;
              w_cnt_nxt   = 8'd1;
            end
          end else begin
            w_err = 1'b1;
          end
        end
      end

      PRESS_DB: begin
        if (!code_in[4] || (code_in[3:0] != r_cand)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_hit) begin
          w_accept    = 1'b1;
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      HELD: begin
        if (!code_in[4]) begin
          if (DEBOUNCE == 1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = REL_DB;
            w_cnt_nxt   = 8'd1;
          end
        end
      end

      REL_DB: begin
        if (code_in[4]) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_hit) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // With DEBOUNCE==1 the accept happens straight out of IDLE, before the
  // candidate register has been loaded.
  assign w_acc_digit = (r_state == IDLE) ? code_in[3:0] : r_cand;

  // ---------------------------------------------------------------------------
  // Entry buffer: a committing cycle first empties the buffer, then any
  // same-cycle accept lands in the fresh entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_commit_go   = commit && (r_count != '0);
    w_base_digits = w_commit_go ? '0 : r_digits;
    w_base_count  = w_commit_go ? '0 : r_count;
    w_shifted     = w_base_digits << 4;
    w_shifted[3:0] = w_acc_digit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= '0;
      r_count  <= '0;
      r_strobe <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_value  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= w_err;

      if (clr) begin
        // clr wins over commit and swallows any same-cycle accept
        r_digits <= '0;
        r_count  <= '0;
      end else begin
        if (w_commit_go) begin
          r_value  <= r_digits;
          r_valid  <= 1'b1;
          r_digits <= '0;
          r_count  <= '0;
        end
        if (w_accept) begin
          if (w_base_count != FULL_CNT) begin
            r_digits <= w_shifted;
            r_count  <= w_base_count + 1'b1;
            r_strobe <= 1'b1;
          end else begin
`ifdef KEYBUF_ROLLOVER_EN
            r_digits <= w_shifted;
            r_strobe <= 1'b1;
`else
            r_ovf    <= 1'b1;
`endif
          end
        end
      end
    end
  end

  assign digits_out  = r_digits;
  assign count       = r_count;
  assign full        = (r_count == FULL_CNT);
  assign key_strobe  = r_strobe;
  assign overflow    = r_ovf;
  assign key_error   = r_err;
  assign value_out   = r_value;
  assign value_valid = r_valid;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
module tb_keypad_digit_buffer;

  localparam int DIGITS = 4;
  localparam int DB     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  code_in;
  logic        clr;
  logic        commit;
  logic [15:0] digits_out;
  logic [2:0]  count;
  logic        full;
  logic        key_strobe;
  logic        overflow;
  logic        key_error;
  logic [15:0] value_out;
  logic        value_valid;

  always #5 clk = ~clk;

  keypad_digit_buffer #(
    .DIGITS   (DIGITS),
    .DEBOUNCE (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .clr         (clr),
    .commit      (commit),
    .digits_out  (digits_out),
    .count       (count),
    .full        (full),
    .key_strobe  (key_strobe),
    .overflow    (overflow),
    .key_error   (key_error),
    .value_out   (value_out),
    .value_valid (value_valid)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: debounced key = run of identical samples; buffer = queue
  // ---------------------------------------------------------------------------
  int          m_q[$];
  bit          m_held;
  int          m_run;
  int          m_cand;
  logic [15:0] m_val;
  bit          m_stb, m_ovf, m_err, m_vv;

  function automatic logic [15:0] q_value();
    logic [15:0] v;
    v = '0;
    foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
    return v;
  endfunction

  task automatic model_step(input bit r, input logic [4:0] code, input bit c, input bit cm);
    bit acc;
    bit p;
    int d;
    acc = 0;
    p = code[4];
    d = int'(code[3:0]);
    m_stb = 0; m_ovf = 0; m_err = 0; m_vv = 0;
    if (r) begin
      m_q.delete(); m_held = 0; m_run = 0; m_cand = 0; m_val = '0;
      return;
    end
    if (!m_held) begin
      if (m_run == 0) begin
        if (p && d <= 9) begin
          m_cand = d; m_run = 1;
          if (m_run >= DB) begin acc = 1; m_held = 1; m_run = 0; end
        end else if (p) begin
          m_err = 1;
        end
      end else if (p && d == m_cand) begin
        m_run++;
        if (m_run >= DB) begin acc = 1; m_held = 1; m_run = 0; end
      end else begin
        m_run = 0;
      end
    end else begin
      if (p) m_run = 0;
      else begin
        m_run++;
        if (m_run >= DB) begin m_held = 0; m_run = 0; end
      end
    end
    if (c) begin
      m_q.delete();
    end else begin
      if (cm && m_q.size() > 0) begin
        m_val = q_value(); m_vv = 1; m_q.delete();
      end
      if (acc) begin
        if (m_q.size() < DIGITS) begin
          m_q.push_back(m_cand); m_stb = 1;
        end else begin
`ifdef KEYBUF_ROLLOVER_EN
          void'(m_q.pop_front()); m_q.push_back(m_cand); m_stb = 1;
`else
          m_ovf = 1;
`endif
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input logic [4:0] code, input bit c, input bit cm);
    @(negedge clk);
    rst = r; code_in = code; clr = c; commit = cm;
    @(posedge clk);
    #1;
    model_step(r, code, c, cm);
    check("digits",   64'(digits_out),  64'(q_value()));
    check("count",    64'(count),       64'(m_q.size()));
    check("full",     64'(full),        64'(m_q.size() == DIGITS));
    check("strobe",   64'(key_strobe),  64'(m_stb));
    check("overflow", 64'(overflow),    64'(m_ovf));
    check("error",    64'(key_error),   64'(m_err));
    check("valid",    64'(value_valid), 64'(m_vv));
    check("value",    64'(value_out),   64'(m_val));
  endtask

  // ---------------------------------------------------------------------------
  // Directed table: each row holds inputs for ncyc cycles; pulses are counted
  // over the row and buffer state checked at its end.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          rst;
    logic [4:0]  code;
    bit          clr;
    bit          commit;
    int          ncyc;
    logic [15:0] exp_dig;
    int          exp_cnt;
    int          exp_stb;
    int          exp_ovf;
    int          exp_err;
    int          exp_vv;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input logic [4:0] code, input bit c, input bit cm, input int n,
                     input logic [15:0] dig, input int cnt, input int stb, input int ovf,
                     input int err, input int vv, input logic [15:0] val);
    vec_t v;
    v.rst = r; v.code = code; v.clr = c; v.commit = cm; v.ncyc = n;
    v.exp_dig = dig; v.exp_cnt = cnt; v.exp_stb = stb; v.exp_ovf = ovf;
    v.exp_err = err; v.exp_vv = vv; v.exp_val = val;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] acc_dig;
    logic [4:0]  rcode;
    bit          rr, rc, rcm;

    rst = 1'b1; code_in = '0; clr = 1'b0; commit = 1'b0;
    m_held = 0; m_run = 0; m_cand = 0; m_val = '0;

    // Single press, held 10 cycles, then released
    add(1, 5'h00, 0, 0, 2,  16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h13, 0, 0, 10, 16'h0003, 1, 1, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 5,  16'h0003, 1, 0, 0, 0, 0, 16'h0000);
    // Bounce on digit 7, then a clean 8 proves the FSM returned to IDLE
    add(1, 5'h00, 0, 0, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h17, 0, 0, 2,  16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h17, 0, 0, 6,  16'h0007, 1, 1, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 4,  16'h0007, 1, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h18, 0, 0, 4,  16'h0078, 2, 1, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 4,  16'h0078, 2, 0, 0, 0, 0, 16'h0000);
    // Fill with 1,2,3,4 then press 5
    add(1, 5'h00, 0, 0, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    acc_dig = '0;
    for (int k = 1; k <= 4; k++) begin
      acc_dig = (acc_dig << 4) | 16'(k);
      add(0, 5'(16 + k), 0, 0, 4, acc_dig, k, 1, 0, 0, 0, 16'h0000);
      add(0, 5'h00,      0, 0, 4, acc_dig, k, 0, 0, 0, 0, 16'h0000);
    end
`ifdef KEYBUF_ROLLOVER_EN
    add(0, 5'h15, 0, 0, 4,  16'h2345, 4, 1, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 4,  16'h2345, 4, 0, 0, 0, 0, 16'h0000);
`else
    add(0, 5'h15, 0, 0, 4,  16'h1234, 4, 0, 1, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 4,  16'h1234, 4, 0, 0, 0, 0, 16'h0000);
`endif
    // Enter 1,2 and commit twice
    add(1, 5'h00, 0, 0, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h11, 0, 0, 4,  16'h0001, 1, 1, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 4,  16'h0001, 1, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h12, 0, 0, 4,  16'h0012, 2, 1, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 4,  16'h0012, 2, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 1, 1,  16'h0000, 0, 0, 0, 0, 1, 16'h0012);
    add(0, 5'h00, 0, 1, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0012);
    // Invalid digit
    add(0, 5'h1C, 0, 0, 1,  16'h0000, 0, 0, 0, 1, 0, 16'h0012);
    add(0, 5'h00, 0, 0, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0012);
    // Enter 6, then clr on the accept edge of 9
    add(0, 5'h16, 0, 0, 4,  16'h0006, 1, 1, 0, 0, 0, 16'h0012);
    add(0, 5'h00, 0, 0, 4,  16'h0006, 1, 0, 0, 0, 0, 16'h0012);
    add(0, 5'h19, 0, 0, 3,  16'h0006, 1, 0, 0, 0, 0, 16'h0012);
    add(0, 5'h19, 1, 0, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0012);
    add(0, 5'h19, 0, 0, 3,  16'h0000, 0, 0, 0, 0, 0, 16'h0012);
    add(0, 5'h00, 0, 0, 4,  16'h0000, 0, 0, 0, 0, 0, 16'h0012);
    // Enter 6, then commit on the accept edge of 8
    add(0, 5'h16, 0, 0, 4,  16'h0006, 1, 1, 0, 0, 0, 16'h0012);
    add(0, 5'h00, 0, 0, 4,  16'h0006, 1, 0, 0, 0, 0, 16'h0012);
    add(0, 5'h18, 0, 0, 3,  16'h0006, 1, 0, 0, 0, 0, 16'h0012);
    add(0, 5'h18, 0, 1, 1,  16'h0008, 1, 1, 0, 0, 1, 16'h0006);
    add(0, 5'h00, 0, 0, 4,  16'h0008, 1, 0, 0, 0, 0, 16'h0006);
    // clr beats commit
    add(0, 5'h00, 1, 1, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0006);
    // Reset during press debounce with the key still held
    add(0, 5'h15, 0, 0, 2,  16'h0000, 0, 0, 0, 0, 0, 16'h0006);
    add(1, 5'h15, 0, 0, 1,  16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h15, 0, 0, 3,  16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 5'h15, 0, 0, 1,  16'h0005, 1, 1, 0, 0, 0, 16'h0000);
    add(0, 5'h00, 0, 0, 4,  16'h0005, 1, 0, 0, 0, 0, 16'h0000);

    foreach (vecs[i]) begin
      int s, o, e, vv;
      s = 0; o = 0; e = 0; vv = 0;
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        cycle(vecs[i].rst, vecs[i].code, vecs[i].clr, vecs[i].commit);
        s  += int'(key_strobe);
        o  += int'(overflow);
        e  += int'(key_error);
        vv += int'(value_valid);
      end
      check($sformatf("row%0d_digits", i),   64'(digits_out), 64'(vecs[i].exp_dig));
      check($sformatf("row%0d_count", i),    64'(count),      64'(vecs[i].exp_cnt));
      check($sformatf("row%0d_strobes", i),  64'(s),          64'(vecs[i].exp_stb));
      check($sformatf("row%0d_overflow", i), 64'(o),          64'(vecs[i].exp_ovf));
      check($sformatf("row%0d_errors", i),   64'(e),          64'(vecs[i].exp_err));
      check($sformatf("row%0d_valids", i),   64'(vv),         64'(vecs[i].exp_vv));
      check($sformatf("row%0d_value", i),    64'(value_out),  64'(vecs[i].exp_val));
    end

    // Hand sequence: strobe appears only after the DEBOUNCE-th edge
    cycle(1, 5'h00, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 5'h13, 0, 0);
      check($sformatf("strobe_edge%0d", i + 1), 64'(key_strobe), 64'(i == DB - 1));
    end
    for (int i = 0; i < 4; i++) cycle(0, 5'h00, 0, 0);

    // Hand sequence: rapid re-press during release debounce does not re-accept
    cycle(0, 5'h14, 0, 0); cycle(0, 5'h14, 0, 0); cycle(0, 5'h14, 0, 0); cycle(0, 5'h14, 0, 0);
    cycle(0, 5'h00, 0, 0); cycle(0, 5'h00, 0, 0); cycle(0, 5'h14, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 5'h00, 0, 0);
    check("repress_digits", 64'(digits_out), 64'(16'h0034));
    check("repress_count",  64'(count),      64'(2));

    // Randomized phase against the model
    rcode = '0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 4)       rcode = {1'b0, 4'($urandom)};
        else if (sel < 9)  rcode = {1'b1, 4'($urandom_range(0, 9))};
        else               rcode = {1'b1, 4'($urandom_range(10, 15))};
      end
      rr  = ($urandom_range(0, 199) == 0);
      rc  = ($urandom_range(0, 39) == 0);
      rcm = ($urandom_range(0, 14) == 0);
      cycle(rr, rcode, rc, rcm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_digit_buffer.md
Name: keypad_digit_buffer

Overview:
- Sequential stage directly downstream of the 10-key input encoder.
- Consumes the encoder's 5-bit code: bit 4 is the key-pressed flag, bits 3:0 are the BCD digit.
- Debounces press and release, accepts one digit per physical press, and shifts accepted digits into a multi-digit BCD entry buffer.
- Hands a completed value to the consumer on commit.

Parameters:
- DIGITS, 4, number of BCD digits held (1..8).
- DEBOUNCE, 4, consecutive identical samples required to accept a press or a release (1..255).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- code_in  input  5  encoder output; [4]=pressed, [3:0]=BCD digit.
- clr  input  1  synchronous clear of the entry buffer.
- commit  input  1  capture the buffer into value_out and clear the buffer.
- digits_out  output  4*DIGITS  entry buffer; newest digit in [3:0].
- count  output  $clog2(DIGITS+1)  number of digits entered.
- full  output  1  high when count==DIGITS.
- key_strobe  output  1  one-cycle pulse per accepted digit.
- overflow  output  1  one-cycle pulse when a digit is dropped because the buffer is full.
- key_error  output  1  one-cycle pulse when a press has digit >9.
- value_out  output  4*DIGITS  last committed value.
- value_valid  output  1  one-cycle pulse when value_out updates.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, debounce counter 0. Reset mid-operation aborts any debounce; a key still held must debounce fully again.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB. An 8-bit counter cnt tracks debounce progress.
- IDLE, code_in[4]=1 and digit<=9: latch the candidate digit, set cnt=1, go to PRESS_DB. If DEBOUNCE==1, accept immediately and go to HELD.
- IDLE, code_in[4]=1 and digit>9: key_error pulses next cycle and the FSM stays in IDLE.
- PRESS_DB, pressed flag drops or digit differs from candidate: go to IDLE, cnt=0.
- PRESS_DB, otherwise: cnt++. On the edge where cnt would reach DEBOUNCE, accept the digit and go to HELD.
- Press latency: a press stable from before edge 1 is accepted at edge DEBOUNCE. key_strobe and the new digits_out are visible in the following cycle.
- HELD: code changes are ignored and there is no auto-repeat. When code_in[4]=0, go to REL_DB with cnt=1, or straight to IDLE if DEBOUNCE==1.
- REL_DB: code_in[4]=1 returns to HELD. Once release has been sampled DEBOUNCE consecutive times, go to IDLE.
- Accept with count<DIGITS: digits_out <= {digits_out shifted left 4, digit}; count++; key_strobe=1.
- Accept with count==DIGITS: digits_out unchanged, overflow=1, key_strobe=0.
- full is combinational from count.
- commit with count>0: value_out <= digits_out as registered before any same-cycle accept; value_valid=1; buffer cleared and count=0.
- commit with count==0: ignored, no pulse.
- commit in the same cycle as accept: commit captures the old contents. The accepted digit becomes the sole digit of the new entry (count=1, key_strobe=1).
- clr: digits_out=0, count=0. A same-cycle accept is discarded (no key_strobe, no overflow) and the FSM still advances to HELD.
- clr takes priority over commit: no value_valid.
- clr and commit do not affect the FSM or value_out, except commit updating value_out as described.
- All pulse outputs are registered and high for exactly one cycle.

Optional Feature:
- Macro KEYBUF_ROLLOVER_EN.
- Defined: accept while full shifts anyway and discards the oldest digit. count stays DIGITS, key_strobe=1, overflow is never asserted (tied 0).
- Undefined: drop-and-flag behaviour as in Behaviour.

Test Plan:
- Reset, then code_in=5'b10011 held 10 cycles -> exactly one key_strobe, one cycle after edge 4; digits_out=16'h0003, count=1.
- Bounce: digit 7 for 2 cycles, released 1 cycle, digit 7 for 6 cycles, then release for 4 cycles -> one key_strobe, digits_out=16'h0007, FSM back in IDLE.
- Enter 1,2,3,4 then 5 (each press+release debounced) -> digits_out=16'h1234, full=1, overflow one pulse. With KEYBUF_ROLLOVER_EN: 16'h2345, key_strobe pulses, overflow stays 0.
- Enter 1,2, then commit -> value_out=16'h0012, value_valid one cycle, digits_out=0, count=0. A second commit gives no pulse.
- code_in=5'b11100 -> key_error one pulse, no key_strobe, digits unchanged. clr asserted on the accept edge of digit 9 -> digits_out=0, no key_strobe.
- rst asserted while in PRESS_DB with cnt=2, key kept held -> all outputs 0 after reset. A new acceptance occurs DEBOUNCE edges after rst deasserts.
